// File: rtl/trng_pkg.sv
// Shared types, default parameters and the von Neumann pair corrector
// for the TRNG bit source.
package trng_pkg;

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        RUN    = 2'd1,
        FAIL   = 2'd2
    } trng_state_t;

    localparam int DEF_DEPTH          = 16;
    localparam int DEF_REP_LIMIT      = 32;
    localparam int DEF_WARMUP_SAMPLES = 64;
    localparam int DEF_SYNC_STAGES    = 2;

    typedef struct packed {
        logic bit_val;
        logic valid;
    } vn_out_t;

    // (0,1) -> 0 and (1,0) -> 1: the output is the first sample
    function automatic vn_out_t vn_correct(input logic first,
                                           input logic second);
        vn_out_t r;
        r.bit_val = first;
        r.valid   = first ^ second;
        return r;
    endfunction

endpackage

// File: rtl/trng_bit_source_if.sv
// Single-bit consumer handshake between the entropy source and the
// word-assembly stage.
interface trng_bit_source_if;
    logic trng_bit;
    logic bit_valid;
    logic trng_next;

    modport master (
        output trng_bit,
        output bit_valid,
        input  trng_next
    );

    modport slave (
        input  trng_bit,
        input  bit_valid,
        output trng_next
    );
endinterface

// File: rtl/trng_bit_fifo.sv
// Synchronous single-bit FIFO with flush; no fall-through, a push while
// full is dropped unless a pop frees the slot in the same cycle.
module trng_bit_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic                       i_push_bit,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic                       o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] r_mem;
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [LW-1:0]    r_level;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_level == LW'(DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push && !reset && !i_flush) begin
            r_mem[r_wr] <= i_push_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            r_level <= r_level + LW'(w_do_push) - LW'(w_do_pop);
        end
    end

    assign o_head  = r_mem[r_rd];
    assign o_level = r_level;

endmodule

// File: rtl/trng_bit_source.sv
// Entropy front end: synchronizer, repetition-count health test,
// von Neumann debiasing and a bit FIFO feeding one bit per request.
module trng_bit_source
    import trng_pkg::*;
#(
    parameter int DEPTH          = DEF_DEPTH,
    parameter int REP_LIMIT      = DEF_REP_LIMIT,
    parameter int WARMUP_SAMPLES = DEF_WARMUP_SAMPLES,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       raw_entropy,
    input  logic                       clear_fail,
    trng_bit_source_if.master          bus,
    output logic                       health_fail,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level
);
    localparam int LW = $clog2(DEPTH + 1);

    trng_state_t r_state;
    trng_state_t w_state_next;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_samp;
    logic                   r_first;
    logic                   r_phase;
    logic [7:0]             r_rep;
    logic [9:0]             r_warm;

    logic          w_s;
    logic [7:0]    w_rep_next;
    logic          w_rep_hit;
    logic          w_warm_done;
    vn_out_t       w_vn;
    logic          w_push;
    logic          w_pop;
    logic          w_bit_valid;
    logic          w_head;
    logic [LW-1:0] w_level;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else if (en) begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], raw_entropy};
        end
    end

    assign w_rep_next = (w_s != r_samp)        ? 8'd1  :
                        (r_rep == 8'(REP_LIMIT)) ? r_rep :
                        r_rep + 8'd1;

    assign w_rep_hit   = en && (r_state != FAIL) &&
                         (w_rep_next == 8'(REP_LIMIT));
    assign w_warm_done = (r_warm == 10'(WARMUP_SAMPLES - 1));
    assign w_vn        = vn_correct(r_first, w_s);

    // A health hit wins over the push of the pair it completes
    assign w_push = en && (r_state == RUN) && r_phase &&
                    w_vn.valid && !w_rep_hit;

    assign w_bit_valid = en && (r_state == RUN) && (w_level != '0);
    assign w_pop       = bus.trng_next && w_bit_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= WARMUP;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (en) begin
            unique case (r_state)
                WARMUP: begin
                    if (w_rep_hit) begin
                        w_state_next = FAIL;
                    end else if (w_warm_done) begin
                        w_state_next = RUN;
                    end
                end
                RUN: begin
                    if (w_rep_hit) begin
                        w_state_next = FAIL;
                    end
                end
                FAIL: begin
                    if (clear_fail) begin
                        w_state_next = WARMUP;
                    end
                end
                default: w_state_next = WARMUP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_samp  <= 1'b0;
            r_first <= 1'b0;
            r_phase <= 1'b0;
            r_rep   <= 8'd1;
            r_warm  <= '0;
        end else if (en) begin
            r_samp <= w_s;
            unique case (r_state)
                WARMUP: begin
                    r_rep   <= w_rep_next;
                    r_warm  <= r_warm + 10'd1;
                    r_phase <= 1'b0;
                end
                RUN: begin
                    r_rep <= w_rep_next;
                    if (!r_phase) begin
                        r_first <= w_s;
                    end
                    r_phase <= ~r_phase;
                end
                FAIL: begin
                    if (clear_fail) begin
                        r_rep   <= 8'd1;
                        r_warm  <= '0;
                        r_phase <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    trng_bit_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_push),
        .i_push_bit(w_vn.bit_val),
        .i_pop     (w_pop),
        .i_flush   (w_rep_hit),
        .o_head    (w_head),
        .o_level   (w_level)
    );

    assign bus.trng_bit  = w_bit_valid & w_head;
    assign bus.bit_valid = w_bit_valid;
    assign health_fail   = (r_state == FAIL);
    assign fifo_level    = w_level;

endmodule
